crc_bit_feeder: RTL and testbench

// - Upstream stage of lfsrN: accepts message bytes over a valid/ready handshake and

---
 rtl/crc_bit_feeder_pkg.sv | 14 +
 rtl/crc_bit_feeder_if.sv | 16 +
 rtl/crc_bit_feeder_piso.sv | 68 ++++++
 rtl/crc_bit_feeder.sv | 84 ++++++++
 tb/tb_crc_bit_feeder.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/crc_bit_feeder_pkg.sv
// Shared definitions for the CRC bit feeder: default widths and the FSM state encoding.
package crc_bit_feeder_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int CNT_BITS_DEF   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/crc_bit_feeder_if.sv
// Word stream into the feeder: data/last qualified by valid, accepted when ready.
interface crc_bit_feeder_if
    import crc_bit_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic [DATA_WIDTH-1:0] byte_data;
    logic                  byte_valid;
    logic                  byte_last;
    logic                  byte_ready;

    modport master (output byte_data, output byte_valid, output byte_last, input byte_ready);
    modport slave  (input byte_data, input byte_valid, input byte_last, output byte_ready);

endinterface

// File: rtl/crc_bit_feeder_piso.sv
// Parallel-in serial-out word register with bit counter; shifts toward the selected end.
module crc_bit_feeder_piso
    import crc_bit_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_BITS   = CNT_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  last_i,
    input  logic                  reflect_i,
    output logic                  full_o,
    output logic                  bit_o,
    output logic                  last_bit_o,
    output logic                  held_last_o
);

    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic                  full_q, full_d;
    logic                  held_last_q, held_last_d;

    assign full_o      = full_q;
    assign held_last_o = held_last_q;
    assign bit_o       = reflect_i ? sr_q[0] : sr_q[DATA_WIDTH-1];
    assign last_bit_o  = full_q && (cnt_q == CNT_BITS'(DATA_WIDTH - 1));

    // A load can only coincide with the final bit, so it simply overwrites the drained word.
    always_comb begin
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        full_d      = full_q;
        held_last_d = held_last_q;
        if (clr_i) begin
            sr_d        = '0;
            cnt_d       = '0;
            full_d      = 1'b0;
            held_last_d = 1'b0;
        end else if (load_i) begin
            sr_d        = din_i;
            cnt_d       = '0;
            full_d      = 1'b1;
            held_last_d = last_i;
        end else if (full_q) begin
            sr_d  = reflect_i ? (sr_q >> 1) : (sr_q << 1);
            cnt_d = cnt_q + CNT_BITS'(1);
            if (last_bit_o) full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q        <= '0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            held_last_q <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            held_last_q <= held_last_d;
        end
    end

endmodule

// File: rtl/crc_bit_feeder.sv
// Serializes a framed word stream into LFSR load/shift/data controls at one bit per clock.
module crc_bit_feeder
    import crc_bit_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_BITS   = CNT_BITS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             reflect_in,
    input  logic             abort,
    crc_bit_feeder_if.slave  byte_if,
    output logic             lfsr_load,
    output logic             lfsr_shift,
    output logic             lfsr_data,
    output logic             busy,
    output logic             frame_done
);

    state_t state_q, state_d;
    logic   reflect_q, reflect_d;
    logic   hs;
    logic   full, ser_bit, last_bit, held_last;

    assign hs = byte_if.byte_valid && byte_if.byte_ready;

    crc_bit_feeder_piso #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_BITS   (CNT_BITS)
    ) u_piso (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (abort || (state_q != ST_RUN)),
        .load_i      (hs),
        .din_i       (byte_if.byte_data),
        .last_i      (byte_if.byte_last),
        .reflect_i   (reflect_q),
        .full_o      (full),
        .bit_o       (ser_bit),
        .last_bit_o  (last_bit),
        .held_last_o (held_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            reflect_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            reflect_q <= reflect_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        reflect_d = reflect_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    state_d   = ST_LOAD;
                    reflect_d = reflect_in;
                end
                ST_LOAD: state_d = ST_RUN;
                ST_RUN:  if (last_bit && held_last) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Everything below decodes registered state only, so no input reaches an output combinationally.
    always_comb begin
        lfsr_load          = (state_q == ST_LOAD);
        lfsr_shift         = (state_q == ST_RUN) && full;
        lfsr_data          = lfsr_shift && ser_bit;
        busy               = (state_q != ST_IDLE);
        frame_done         = (state_q == ST_DONE);
        byte_if.byte_ready = (state_q == ST_RUN) && (!full || (last_bit && !held_last));
    end

endmodule

// File: tb/tb_crc_bit_feeder.sv
// Directed bench: single-word table, multi-word CRC-32 frames, stalls, abort and async reset.
module tb_crc_bit_feeder;

    typedef logic [7:0] byte_t;
    typedef struct {
        byte_t data;
        logic  refl;
        byte_t seq;   // serial bits, first bit in [7]
        byte_t crc8;  // CRC-8 poly 0x07, init 0x00, no final xor
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, reflect_in = 1'b0, abort = 1'b0;
    logic lfsr_load, lfsr_shift, lfsr_data, busy, frame_done;

    crc_bit_feeder_if #(.DATA_WIDTH(8)) bif ();

    crc_bit_feeder #(.DATA_WIDTH(8), .CNT_BITS(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .reflect_in (reflect_in),
        .abort      (abort),
        .byte_if    (bif),
        .lfsr_load  (lfsr_load),
        .lfsr_shift (lfsr_shift),
        .lfsr_data  (lfsr_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Downstream observer standing in for lfsrN plus stream statistics.
    int          shift_cnt = 0, load_cnt = 0, done_cnt = 0, stall_cnt = 0;
    int          ready_early = 0, ready_8th = 0, frame_idx = 0;
    logic        started = 1'b0;
    logic        bits_q[$];
    logic [7:0]  crc8_m = 8'h00;
    logic [31:0] crc32_m = 32'hFFFF_FFFF;

    always @(negedge clk) begin
        if (!rst) begin
            if (lfsr_load) begin
                load_cnt  <= load_cnt + 1;
                crc8_m    <= 8'h00;
                crc32_m   <= 32'hFFFF_FFFF;
                started   <= 1'b0;
                frame_idx <= 0;
            end
            if (lfsr_shift) begin
                bits_q.push_back(lfsr_data);
                if (bif.byte_ready) begin
                    if (frame_idx % 8 == 7) ready_8th <= ready_8th + 1;
                    else ready_early <= ready_early + 1;
                end
                frame_idx <= frame_idx + 1;
                shift_cnt <= shift_cnt + 1;
                started   <= 1'b1;
                crc8_m    <= {crc8_m[6:0], 1'b0} ^ ((crc8_m[7] ^ lfsr_data) ? 8'h07 : 8'h00);
                crc32_m   <= {crc32_m[30:0], 1'b0} ^ ((crc32_m[31] ^ lfsr_data) ? 32'h04C1_1DB7 : 32'h0);
            end else if (started && busy && !frame_done && !lfsr_load) begin
                stall_cnt <= stall_cnt + 1;
            end
            if (frame_done) begin
                done_cnt <= done_cnt + 1;
                started  <= 1'b0;
            end
        end
    end

    function automatic logic [31:0] crc32_sw(input byte_t msg[$], input logic refl);
        logic [31:0] c = 32'hFFFF_FFFF;
        logic        b;
        foreach (msg[i]) begin
            for (int k = 0; k < 8; k++) begin
                b = refl ? msg[i][k] : msg[i][7-k];
                c = (c[31] ^ b) ? ({c[30:0], 1'b0} ^ 32'h04C1_1DB7) : {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input byte_t msg[$], input logic refl, input int gap,
                              input int abort_at, output logic aborted);
        int  base;
        bit  got;
        base    = shift_cnt;
        aborted = 1'b0;
        start = 1'b1; reflect_in = refl;
        bif.byte_valid = 1'b1; bif.byte_data = msg[0]; bif.byte_last = (msg.size() == 1);
        step();
        start = 1'b0;
        check("ready_low_in_load", {31'd0, bif.byte_ready}, 32'd0);
        for (int w = 0; w < msg.size(); w++) begin
            bif.byte_data = msg[w]; bif.byte_last = (w == msg.size() - 1); bif.byte_valid = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 64; t++) begin
                if (abort_at >= 0 && lfsr_shift && (shift_cnt - base) == abort_at) begin
                    abort = 1'b1; bif.byte_valid = 1'b0;
                    step();
                    abort = 1'b0;
                    aborted = 1'b1;
                    return;
                end
                if (bif.byte_ready) begin
                    step();
                    got = 1'b1;
                    break;
                end
                step();
            end
            bif.byte_valid = 1'b0;
            if (!got) begin
                check("handshake_timeout", 32'd0, 32'd1);
                return;
            end
            if (gap > 0 && w != msg.size() - 1) begin
                for (int t = 0; t < 64 && !bif.byte_ready; t++) step();
                repeat (gap) step();
            end
        end
        got = 1'b0;
        for (int t = 0; t < 64; t++) begin
            if (frame_done) begin
                got = 1'b1;
                break;
            end
            step();
        end
        if (!got) check("frame_done_timeout", 32'd0, 32'd1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t        vt[5];
    byte_t       msg[$];
    logic        ab;
    logic [7:0]  s;
    logic [31:0] crc_gapless;
    int          b_shift, b_load, b_done, b_stall, b_early, b_8th;

    task automatic snap();
        b_shift = shift_cnt; b_load = load_cnt; b_done = done_cnt;
        b_stall = stall_cnt; b_early = ready_early; b_8th = ready_8th;
    endtask

    initial begin
        vt[0] = '{data: 8'hA5, refl: 1'b0, seq: 8'hA5, crc8: 8'h72};
        vt[1] = '{data: 8'hA5, refl: 1'b1, seq: 8'hA5, crc8: 8'h72};
        vt[2] = '{data: 8'h01, refl: 1'b0, seq: 8'h01, crc8: 8'h07};
        vt[3] = '{data: 8'h01, refl: 1'b1, seq: 8'h80, crc8: 8'h89};
        vt[4] = '{data: 8'hFF, refl: 1'b0, seq: 8'hFF, crc8: 8'hF3};

        bif.byte_valid = 1'b0; bif.byte_data = 8'h00; bif.byte_last = 1'b0;
        #12;
        check("reset_outputs", {26'd0, lfsr_load, lfsr_shift, lfsr_data, busy, frame_done, bif.byte_ready}, 32'd0);
        rst = 1'b0;
        step(); step();
        check("idle_after_reset", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            snap();
            msg = '{vt[i].data};
            send_frame(msg, vt[i].refl, 0, -1, ab);
            for (int k = 0; k < 8; k++) s[7-k] = bits_q[b_shift + k];
            check($sformatf("v%0d_load_pulses", i), load_cnt - b_load, 1);
            check($sformatf("v%0d_shift_count", i), shift_cnt - b_shift, 8);
            check($sformatf("v%0d_bit_seq", i), {24'd0, s}, {24'd0, vt[i].seq});
            check($sformatf("v%0d_frame_done", i), done_cnt - b_done, 1);
            check($sformatf("v%0d_crc8", i), {24'd0, crc8_m}, {24'd0, vt[i].crc8});
            check($sformatf("v%0d_ready_early", i), ready_early - b_early, 0);
            check($sformatf("v%0d_idle_after", i), {31'd0, busy}, 32'd0);
        end

        // Four words back to back
        msg = '{8'h31, 8'h32, 8'h33, 8'h34};
        snap();
        send_frame(msg, 1'b1, 0, -1, ab);
        crc_gapless = crc32_m;
        check("burst_shift_count", shift_cnt - b_shift, 32);
        check("burst_no_stall", stall_cnt - b_stall, 0);
        check("burst_ready_on_8th", ready_8th - b_8th, 3);
        check("burst_ready_early", ready_early - b_early, 0);
        check("burst_crc32", crc_gapless, crc32_sw(msg, 1'b1));

        // Same words with a 3-cycle valid gap between each
        snap();
        send_frame(msg, 1'b1, 3, -1, ab);
        check("gap_shift_count", shift_cnt - b_shift, 32);
        check("gap_stall_cycles", stall_cnt - b_stall, 9);
        check("gap_crc32_vs_gapless", crc32_m, crc_gapless);
        check("gap_frame_done", done_cnt - b_done, 1);

        // Abort on the 5th shift of word 2
        snap();
        send_frame(msg, 1'b0, 0, 12, ab);
        check("abort_taken", {31'd0, ab}, 32'd1);
        check("abort_idle_next", {30'd0, busy, lfsr_shift}, 32'd0);
        repeat (4) step();
        check("abort_no_done", done_cnt - b_done, 0);
        check("abort_shift_count", shift_cnt - b_shift, 13);

        // abort beats start in IDLE
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("abort_start_idle", {30'd0, busy, lfsr_load}, 32'd0);
        step();
        check("abort_start_still_idle", {31'd0, busy}, 32'd0);

        snap();
        send_frame(msg, 1'b0, 0, -1, ab);
        check("reseed_load", load_cnt - b_load, 1);
        check("reseed_crc32", crc32_m, crc32_sw(msg, 1'b0));
        check("reseed_done", done_cnt - b_done, 1);

        // Asynchronous reset mid-RUN
        start = 1'b1; reflect_in = 1'b0;
        step();
        start = 1'b0;
        step();
        bif.byte_valid = 1'b1; bif.byte_data = 8'hA5; bif.byte_last = 1'b1;
        step();
        bif.byte_valid = 1'b0;
        step(); step();
        check("pre_reset_shifting", {31'd0, lfsr_shift}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", {26'd0, lfsr_load, lfsr_shift, lfsr_data, busy, frame_done, bif.byte_ready}, 32'd0);
        step();
        rst = 1'b0;
        step();
        check("idle_after_midrun_reset", {29'd0, busy, lfsr_load, lfsr_shift}, 32'd0);

        snap();
        msg = '{8'hA5};
        send_frame(msg, 1'b0, 0, -1, ab);
        check("post_reset_crc8", {24'd0, crc8_m}, 32'h72);
        check("post_reset_done", done_cnt - b_done, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
